// File: rtl/screen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : screen_pkg
// Purpose  : Screen-map geometry constants and scan look-ahead helper shared
//            by the video scan-out stage.
// Revision : 1.0  initial release
// ============================================================================
package screen_pkg;

    localparam int          SCREEN_WORDS  = 8192;
    localparam int          WORDS_PER_ROW = 32;
    localparam int          SCREEN_ROWS   = 256;
    localparam logic [15:0] SCREEN_BASE   = 16'h4000;
    localparam logic [15:0] KBD_ADR       = 16'h6000;

    localparam int          SCR_ADR_W     = 13;
    localparam int          PIX_PER_WORD  = 16;

    typedef struct packed {
        logic [15:0] h;
        logic [15:0] v;
    } scan_pos_t;

    // Raster position 'lead' clocks ahead of (h, v), wrapping line and frame.
    function automatic scan_pos_t look_ahead(input int h, input int v, input int lead,
                                             input int h_total, input int v_total);
        scan_pos_t p;
        int        hp;
        int        vp;
        hp = h + lead;
        vp = v;
        if (hp >= h_total) begin
            hp = hp - h_total;
            vp = (v == v_total - 1) ? 0 : v + 1;
        end
        p.h = 16'(hp);
        p.v = 16'(vp);
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_timing.sv
`default_nettype none
// ============================================================================
// Module   : scan_timing
// Purpose  : Raster h/v counters with display-enable, active-low syncs and a
//            frame-start pulse, all decoded directly from the counter registers.
// Revision : 1.0  initial release
// ============================================================================
module scan_timing #(
    parameter int H_ACTIVE = 512,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 48,
    parameter int H_BACK   = 64,
    parameter int V_ACTIVE = 256,
    parameter int V_FRONT  = 4,
    parameter int V_SYNC   = 4,
    parameter int V_BACK   = 16,
    parameter int H_W      = 10,
    parameter int V_W      = 9
) (
    input  logic           clk,
    input  logic           reset,
    output logic [H_W-1:0] o_h_cnt,
    output logic [V_W-1:0] o_v_cnt,
    output logic           o_de,
    output logic           o_hsync,
    output logic           o_vsync,
    output logic           o_frame_start
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    logic [H_W-1:0] r_h_cnt;
    logic [V_W-1:0] r_v_cnt;

    // Reset parks two clocks before line 0 so its first word can prefetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_h_cnt <= H_W'(c_H_TOTAL - 2);
            r_v_cnt <= V_W'(c_V_TOTAL - 1);
        end else if (r_h_cnt == H_W'(c_H_TOTAL - 1)) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_W'(c_V_TOTAL - 1)) ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    assign o_h_cnt       = r_h_cnt;
    assign o_v_cnt       = r_v_cnt;
    assign o_de          = (r_h_cnt < H_W'(H_ACTIVE)) && (r_v_cnt < V_W'(V_ACTIVE));
    assign o_hsync       = !((r_h_cnt >= H_W'(H_ACTIVE + H_FRONT)) &&
                             (r_h_cnt <  H_W'(H_ACTIVE + H_FRONT + H_SYNC)));
    assign o_vsync       = !((r_v_cnt >= V_W'(V_ACTIVE + V_FRONT)) &&
                             (r_v_cnt <  V_W'(V_ACTIVE + V_FRONT + V_SYNC)));
    assign o_frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/screen_scanner.sv
`default_nettype none
// ============================================================================
// Module   : screen_scanner
// Purpose  : Video scan-out: raster timing, one screen-word fetch per 16
//            pixels, LSB-first pixel serialiser. Optional frame counter is
//            built when SCREEN_FRAME_CNT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module screen_scanner
    import screen_pkg::*;
#(
    parameter int H_ACTIVE = WORDS_PER_ROW * PIX_PER_WORD,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 48,
    parameter int H_BACK   = 64,
    parameter int V_ACTIVE = SCREEN_ROWS,
    parameter int V_FRONT  = 4,
    parameter int V_SYNC   = 4,
    parameter int V_BACK   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [SCR_ADR_W-1:0] scr_adr,
    input  logic [15:0]          scr_data,
    output logic                 pixel,
    output logic                 de,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 frame_start
`ifdef SCREEN_FRAME_CNT_EN
    ,
    output logic [15:0]          frame_cnt
`endif
);

    localparam int c_H_TOTAL       = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_V_TOTAL       = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int c_H_W           = $clog2(c_H_TOTAL);
    localparam int c_V_W           = $clog2(c_V_TOTAL);
    localparam int c_WORDS_PER_ROW = H_ACTIVE / PIX_PER_WORD;
    // Clocks before a word's first pixel: address out, data capture, shift load.
    localparam int c_LEAD_ADR      = 3;
    localparam int c_LEAD_SAMPLE   = 2;
    localparam int c_LEAD_LOAD     = 1;

    logic [c_H_W-1:0]     w_h_cnt;
    logic [c_V_W-1:0]     w_v_cnt;
    logic                 w_de;
    logic                 w_frame_start;
    scan_pos_t            w_pos_adr;
    scan_pos_t            w_pos_smp;
    scan_pos_t            w_pos_load;
    logic                 w_adr_hit;
    logic                 w_smp_hit;
    logic                 w_load_hit;
    logic [SCR_ADR_W-1:0] w_adr_next;

    logic [SCR_ADR_W-1:0] r_scr_adr;
    logic [15:0]          r_next_word;
    logic [15:0]          r_shift;

    scan_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FRONT  (H_FRONT),
        .H_SYNC   (H_SYNC),
        .H_BACK   (H_BACK),
        .V_ACTIVE (V_ACTIVE),
        .V_FRONT  (V_FRONT),
        .V_SYNC   (V_SYNC),
        .V_BACK   (V_BACK),
        .H_W      (c_H_W),
        .V_W      (c_V_W)
    ) u_timing (
        .clk           (clk),
        .reset         (reset),
        .o_h_cnt       (w_h_cnt),
        .o_v_cnt       (w_v_cnt),
        .o_de          (w_de),
        .o_hsync       (hsync),
        .o_vsync       (vsync),
        .o_frame_start (w_frame_start)
    );

    // True when the position is the first pixel of a visible word.
    function automatic logic word_start(input scan_pos_t p);
        return (int'(p.h) < H_ACTIVE) && (p.h[3:0] == 4'd0) && (int'(p.v) < V_ACTIVE);
    endfunction

    always_comb begin
        w_pos_adr  = look_ahead(int'(w_h_cnt), int'(w_v_cnt), c_LEAD_ADR, c_H_TOTAL, c_V_TOTAL);
        w_pos_smp  = look_ahead(int'(w_h_cnt), int'(w_v_cnt), c_LEAD_SAMPLE, c_H_TOTAL, c_V_TOTAL);
        w_pos_load = look_ahead(int'(w_h_cnt), int'(w_v_cnt), c_LEAD_LOAD, c_H_TOTAL, c_V_TOTAL);
        w_adr_hit  = word_start(w_pos_adr);
        w_smp_hit  = word_start(w_pos_smp);
        w_load_hit = word_start(w_pos_load);
        w_adr_next = SCR_ADR_W'(int'(w_pos_adr.v) * c_WORDS_PER_ROW +
                                int'(w_pos_adr.h) / PIX_PER_WORD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_scr_adr   <= '0;
            r_next_word <= '0;
            r_shift     <= '0;
        end else begin
            if (w_adr_hit) begin
                r_scr_adr <= w_adr_next;
            end
            if (w_smp_hit) begin
                r_next_word <= scr_data;
            end
            if (w_load_hit) begin
                r_shift <= r_next_word;
            end else begin
                r_shift <= r_shift >> 1;
            end
        end
    end

    assign scr_adr     = r_scr_adr;
    assign pixel       = w_de & r_shift[0];
    assign de          = w_de;
    assign frame_start = w_frame_start;

`ifdef SCREEN_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_cnt <= '0;
        end else if (w_frame_start) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_screen_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_screen_scanner
// Purpose  : Self-checking bench: a reduced-geometry scanner is checked line
//            by line against a scoreboard; a full-geometry scanner is checked
//            over its first two lines.
// Revision : 1.0  initial release
// ============================================================================
module tb_screen_scanner;

    localparam int HA = 64, HF = 4, HS = 8, HB = 4, HT = HA + HF + HS + HB;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 1, VT = VA + VF + VS + VB;
    localparam int WPR   = HA / 16;
    localparam int ADR_H = 16 * (WPR - 1) - 2;
    localparam int DHT   = 640;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [12:0] scr_adr, scr_adr_d;
    logic [15:0] scr_data, scr_data_d;
    logic        pixel, de, hsync, vsync, frame_start;
    logic        pixel_d, de_d, hsync_d, vsync_d, frame_start_d;
`ifdef SCREEN_FRAME_CNT_EN
    logic [15:0] frame_cnt, frame_cnt_d;
`endif

    logic [15:0] mem   [8192];
    logic [15:0] mem_d [8192];

    assign scr_data   = mem[scr_adr];
    assign scr_data_d = mem_d[scr_adr_d];

    always #5 clk = ~clk;

    screen_scanner #(
        .H_ACTIVE (HA), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_ACTIVE (VA), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .scr_adr     (scr_adr),
        .scr_data    (scr_data),
        .pixel       (pixel),
        .de          (de),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start)
`ifdef SCREEN_FRAME_CNT_EN
        ,
        .frame_cnt   (frame_cnt)
`endif
    );

    screen_scanner dut_d (
        .clk         (clk),
        .reset       (reset),
        .scr_adr     (scr_adr_d),
        .scr_data    (scr_data_d),
        .pixel       (pixel_d),
        .de          (de_d),
        .hsync       (hsync_d),
        .vsync       (vsync_d),
        .frame_start (frame_start_d)
`ifdef SCREEN_FRAME_CNT_EN
        ,
        .frame_cnt   (frame_cnt_d)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [HT-1:0] pix;
        int            de_cnt;
        int            hs_low;
        int            vs_low;
        int            fs_cnt;
        int            adr;
    } line_t;

    line_t exp_q[$];

    // Expected per-line picture and timing, built from the memory image.
    task automatic push_frames(input int nf);
        line_t e;
        for (int f = 0; f < nf; f++) begin
            for (int l = 0; l < VT; l++) begin
                e.pix = '0;
                if (l < VA) begin
                    for (int h = 0; h < HA; h++) e.pix[h] = mem[l * WPR + h / 16][h % 16];
                end
                e.de_cnt = (l < VA) ? HA : 0;
                e.hs_low = HS;
                e.vs_low = (l >= VA + VF && l < VA + VF + VS) ? HT : 0;
                e.fs_cnt = (l == 0) ? 1 : 0;
                e.adr    = (l < VA) ? l * WPR + WPR - 1 : VA * WPR - 1;
                exp_q.push_back(e);
            end
        end
    endtask

    // Call right after the reset-release negedge.
    task automatic collect_lines(input int nl);
        line_t o;
        line_t e;
        @(negedge clk);
        for (int l = 0; l < nl; l++) begin
            o.pix = '0; o.de_cnt = 0; o.hs_low = 0; o.vs_low = 0; o.fs_cnt = 0; o.adr = -1;
            for (int h = 0; h < HT; h++) begin
                @(negedge clk);
                o.pix[h] = pixel;
                if (de)          o.de_cnt++;
                if (!hsync)      o.hs_low++;
                if (!vsync)      o.vs_low++;
                if (frame_start) o.fs_cnt++;
                if (h == ADR_H)  o.adr = int'(scr_adr);
            end
            if (exp_q.size() == 0) begin
                chk($sformatf("sb_empty_l%0d", l), 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("pix_l%0d", l),    o.pix,    e.pix);
                chk($sformatf("de_l%0d", l),     o.de_cnt, e.de_cnt);
                chk($sformatf("hsync_l%0d", l),  o.hs_low, e.hs_low);
                chk($sformatf("vsync_l%0d", l),  o.vs_low, e.vs_low);
                chk($sformatf("fstart_l%0d", l), o.fs_cnt, e.fs_cnt);
                chk($sformatf("adr_l%0d", l),    o.adr,    e.adr);
            end
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_frames(input int nf);
        reset_dut();
        push_frames(nf);
        collect_lines(nf * VT);
    endtask

    task automatic fill(input logic [15:0] val, input bit rnd);
        for (int i = 0; i < 8192; i++) mem[i] = rnd ? 16'($urandom) : val;
    endtask

    // Full-geometry scanner, first two lines after reset release.
    task automatic check_default();
        int ones0 = 0, ones1 = 0, first1 = -1, last1 = -1, hs0 = 0, de0 = 0;
        int de_fall = -1, fs0 = 0, fs_h = -1, vs0 = 0, adr494 = -1;
        @(negedge clk);
        for (int l = 0; l < 2; l++) begin
            for (int h = 0; h < DHT; h++) begin
                @(negedge clk);
                if (l == 0) begin
                    if (pixel_d) begin
                        ones0++;
                        if (first1 < 0) first1 = h;
                        last1 = h;
                    end
                    if (!hsync_d) hs0++;
                    if (de_d) de0++;
                    else if (de_fall < 0) de_fall = h;
                    if (frame_start_d) begin
                        fs0++;
                        fs_h = h;
                    end
                    if (!vsync_d) vs0++;
                    if (h == 494) adr494 = int'(scr_adr_d);
                end else if (pixel_d) begin
                    ones1++;
                end
            end
        end
        chk("dflt_ones_l0",  ones0,   2);
        chk("dflt_first_l0", first1,  0);
        chk("dflt_last_l0",  last1,   511);
        chk("dflt_ones_l1",  ones1,   0);
        chk("dflt_hsync_l0", hs0,     48);
        chk("dflt_de_l0",    de0,     512);
        chk("dflt_defall",   de_fall, 512);
        chk("dflt_fs_cnt",   fs0,     1);
        chk("dflt_fs_h",     fs_h,    0);
        chk("dflt_vsync_l0", vs0,     0);
        chk("dflt_adr494",   adr494,  31);
    endtask

    typedef struct {
        int          line;
        int          h;
        logic [15:0] val;
        bit          rnd;
    } mid_rst_t;

    mid_rst_t mid_tbl[2] = '{
        '{line: 2, h: 20, val: 16'hFFFF, rnd: 1'b0},
        '{line: 8, h: 70, val: 16'h0000, rnd: 1'b1}
    };

    initial begin
        fill(16'h0000, 1'b0);
        for (int i = 0; i < 8192; i++) mem_d[i] = 16'h0000;
        mem_d[0]  = 16'h0001;
        mem_d[31] = 16'h8000;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_pixel",   pixel,       1'b0);
        chk("rst_de",      de,          1'b0);
        chk("rst_hsync",   hsync,       1'b1);
        chk("rst_vsync",   vsync,       1'b1);
        chk("rst_fstart",  frame_start, 1'b0);
        chk("rst_adr",     scr_adr,     13'd0);
        chk("rst_adr_d",   scr_adr_d,   13'd0);
        reset = 1'b0;
        check_default();

        fill(16'h0000, 1'b0); mem[0] = 16'h0001;
        run_frames(1);
        fill(16'h0000, 1'b0); mem[WPR - 1] = 16'h8000;
        run_frames(1);
        fill(16'h0000, 1'b0); mem[VA * WPR - 1] = 16'hFFFF;
        run_frames(1);
        fill(16'h0000, 1'b1);
        run_frames(2);

        foreach (mid_tbl[i]) begin
            fill(mid_tbl[i].val, mid_tbl[i].rnd);
            reset_dut();
            repeat (2 + mid_tbl[i].line * HT + mid_tbl[i].h) @(negedge clk);
            chk($sformatf("mid%0d_pre_de", i), de,
                (mid_tbl[i].line < VA && mid_tbl[i].h < HA) ? 1'b1 : 1'b0);
            reset = 1'b1;
            @(negedge clk);
            chk($sformatf("mid%0d_pixel", i),  pixel,       1'b0);
            chk($sformatf("mid%0d_de", i),     de,          1'b0);
            chk($sformatf("mid%0d_hsync", i),  hsync,       1'b1);
            chk($sformatf("mid%0d_vsync", i),  vsync,       1'b1);
            chk($sformatf("mid%0d_fstart", i), frame_start, 1'b0);
            chk($sformatf("mid%0d_adr", i),    scr_adr,     13'd0);
            @(negedge clk);
            reset = 1'b0;
            push_frames(1);
            collect_lines(VT);
        end

`ifdef SCREEN_FRAME_CNT_EN
        fill(16'h0000, 1'b1);
        run_frames(3);
        chk("fcnt_3", frame_cnt, 16'd3);
        force dut.r_frame_cnt = 16'hFFFF;
        @(negedge clk);
        chk("fcnt_fs_here", frame_start, 1'b1);
        release dut.r_frame_cnt;
        @(negedge clk);
        chk("fcnt_wrap", frame_cnt, 16'd0);
`endif

        chk("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
